// File: rtl/caster_pkg.sv
// Shared types and constants for the multi_caster column responder.
// Contents:
//   DATA_WIDTH - operand width used by the operand record
//   PSUM_W     - partial-sum width (twice the operand width)
//   mc_state_t - caster operating state (normal running / draining for flush)
//   operand_t  - one buffered bus beat: ifmap, filter and incoming psum
package caster_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int PSUM_W     = 2 * DATA_WIDTH;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } mc_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] ifmap;
      logic [DATA_WIDTH-1:0] fltr;
      logic [PSUM_W-1:0]     psum;
   } operand_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   push_i    - write wdata_i (ignored while full)
//   wdata_i   - write data
//   pop_i     - discard the head entry (ignored while empty)
//   rdata_o   - head entry, valid whenever empty_o is low; zero while empty
//   full_o    - no free entry
//   empty_o   - no stored entry
//   count_o   - number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // The head is masked while empty so the storage array needs no reset
   // and the output still reads as zero straight out of reset.
   assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

   // Occupancy follows push/pop; a simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/multi_caster.sv
// MultiCaster: column responder between the horizontal bus and one PE.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   ID, TAG, CASTER_EN            - column index, beat destination, beat present
//   ifmap/fltr/psum_data_B2M      - operand beat from the bus
//   kernel_size                   - kernel size, forwarded to the PE when idle
//   flush                         - level flush request; flush_BUSY reports it
//   READY / VALID / psum_data_M2B - result return handshake to the bus
//   ifmap/fltr_data_M2B           - last operands issued, for reuse forwarding
//   ovf_err                       - sticky: a matching beat hit a full buffer
//   PE_EN, *_M2P, pe_kernel_size  - one-cycle issue strobe and data to the PE
//   PE_READY / PE_VALID / psum_data_P2M - PE result handshake
module multi_caster
   import caster_pkg::*;
#(
   parameter int DATA_WIDTH = caster_pkg::DATA_WIDTH,
   parameter int NUM_COL    = 4,
   parameter int IN_DEPTH   = 4,
   parameter int RES_DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(NUM_COL)-1:0] ID,
   input  logic [$clog2(NUM_COL)-1:0] TAG,
   input  logic                       CASTER_EN,
   input  logic [DATA_WIDTH-1:0]      ifmap_data_B2M,
   input  logic [DATA_WIDTH-1:0]      fltr_data_B2M,
   input  logic [2*DATA_WIDTH-1:0]    psum_data_B2M,
   input  logic [7:0]                 kernel_size,
   input  logic                       flush,
   input  logic                       READY,
   output logic                       VALID,
   output logic [2*DATA_WIDTH-1:0]    psum_data_M2B,
   output logic [DATA_WIDTH-1:0]      ifmap_data_M2B,
   output logic [DATA_WIDTH-1:0]      fltr_data_M2B,
   output logic                       flush_BUSY,
   output logic                       ovf_err,
   output logic                       PE_EN,
   output logic [DATA_WIDTH-1:0]      ifmap_data_M2P,
   output logic [DATA_WIDTH-1:0]      fltr_data_M2P,
   output logic [2*DATA_WIDTH-1:0]    psum_data_M2P,
   output logic [7:0]                 pe_kernel_size,
   output logic                       PE_READY,
   input  logic                       PE_VALID,
   input  logic [2*DATA_WIDTH-1:0]    psum_data_P2M
);

   localparam int CW  = $clog2(RES_DEPTH) + 1;
   localparam int ICW = $clog2(IN_DEPTH) + 1;

   mc_state_t               state_q;
   mc_state_t               state_d;
   logic [CW-1:0]           outstanding_q;
   logic [CW-1:0]           outstanding_d;
   logic                    ovf_q;
   logic                    peEn_q;
   logic [DATA_WIDTH-1:0]   ifmapM2P_q;
   logic [DATA_WIDTH-1:0]   fltrM2P_q;
   logic [2*DATA_WIDTH-1:0] psumM2P_q;
   logic [DATA_WIDTH-1:0]   ifmapM2B_q;
   logic [DATA_WIDTH-1:0]   fltrM2B_q;
   logic [7:0]              kernel_q;

   operand_t                opWdata;
   operand_t                opRdata;
   logic                    opPush;
   logic                    opFull;
   logic                    opEmpty;
   logic [ICW-1:0]          opCount;

   logic                    resPush;
   logic                    resPop;
   logic                    resFull;
   logic                    resEmpty;
   logic [CW-1:0]           resCount;

   logic                    hit;
   logic                    issue;
   logic                    capture;
   logic                    drained;
   logic [CW:0]             inFlight;

   // A beat that arrives together with the flush request already belongs to
   // the flush and is dropped silently, like every beat seen during FLUSH.
   assign hit = CASTER_EN && (TAG == ID) && (state_q == RUN) && !flush;
   assign opPush = hit && !opFull;

   // Issue only when the result buffer is guaranteed room for the answer of
   // every beat already sent to the PE plus this one, so PE results can never
   // overflow it.
   assign inFlight = {1'b0, outstanding_q} + {1'b0, resCount};
   assign issue    = !opEmpty && (inFlight < (CW+1)'(RES_DEPTH));

   // PE_READY is forced low during reset so every output reads zero then.
   assign PE_READY = !resFull && !rst;
   assign capture  = PE_VALID && !resFull && (outstanding_q != '0);
   assign resPush  = capture;
   assign resPop   = VALID && READY;

   assign drained = (opCount == '0) && (outstanding_q == '0) && resEmpty;

   always_comb begin
      opWdata       = '0;
      opWdata.ifmap = ifmap_data_B2M;
      opWdata.fltr  = fltr_data_B2M;
      opWdata.psum  = psum_data_B2M;
   end

   sync_fifo #(
      .WIDTH ($bits(operand_t)),
      .DEPTH (IN_DEPTH)
   ) u_opFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (opPush),
      .wdata_i (opWdata),
      .pop_i   (issue),
      .rdata_o (opRdata),
      .full_o  (opFull),
      .empty_o (opEmpty),
      .count_o (opCount)
   );

   sync_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (RES_DEPTH)
   ) u_resFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (resPush),
      .wdata_i (psum_data_P2M),
      .pop_i   (resPop),
      .rdata_o (psum_data_M2B),
      .full_o  (resFull),
      .empty_o (resEmpty),
      .count_o (resCount)
   );

   // Flush leaves RUN immediately and only returns once every buffered beat
   // and result has left the caster and the request has been released.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush) state_d = FLUSH;
         FLUSH:   if (drained && !flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Beats with the PE: an issue and a capture in the same cycle cancel out.
   always_comb begin
      outstanding_d = outstanding_q;
      case ({issue, capture})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   // Registered control and PE/bus-facing data. The M2P/M2B operand registers
   // load only on issue, so they keep showing the last issued beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         outstanding_q <= '0;
         ovf_q         <= 1'b0;
         peEn_q        <= 1'b0;
         ifmapM2P_q    <= '0;
         fltrM2P_q     <= '0;
         psumM2P_q     <= '0;
         ifmapM2B_q    <= '0;
         fltrM2B_q     <= '0;
         kernel_q      <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         peEn_q        <= issue;
         if (hit && opFull) ovf_q <= 1'b1;
         if (issue) begin
            ifmapM2P_q <= opRdata.ifmap;
            fltrM2P_q  <= opRdata.fltr;
            psumM2P_q  <= opRdata.psum;
            ifmapM2B_q <= opRdata.ifmap;
            fltrM2B_q  <= opRdata.fltr;
         end
         // The PE only sees a new kernel size while it has no work queued.
         if ((opCount == '0) && (outstanding_q == '0)) kernel_q <= kernel_size;
      end
   end

   assign VALID          = !resEmpty;
   assign flush_BUSY     = (state_q == FLUSH);
   assign ovf_err        = ovf_q;
   assign PE_EN          = peEn_q;
   assign ifmap_data_M2P = ifmapM2P_q;
   assign fltr_data_M2P  = fltrM2P_q;
   assign psum_data_M2P  = psumM2P_q;
   assign ifmap_data_M2B = ifmapM2B_q;
   assign fltr_data_M2B  = fltrM2B_q;
   assign pe_kernel_size = kernel_q;

endmodule

// File: tb/tb_multi_caster.sv
// Directed testbench for multi_caster (ID=2, default depths of 4).
module tb_multi_caster;

   logic        clk;
   logic        rst;
   logic [1:0]  ID;
   logic [1:0]  TAG;
   logic        CASTER_EN;
   logic [15:0] ifmap_data_B2M;
   logic [15:0] fltr_data_B2M;
   logic [31:0] psum_data_B2M;
   logic [7:0]  kernel_size;
   logic        flush;
   logic        READY;
   logic        VALID;
   logic [31:0] psum_data_M2B;
   logic [15:0] ifmap_data_M2B;
   logic [15:0] fltr_data_M2B;
   logic        flush_BUSY;
   logic        ovf_err;
   logic        PE_EN;
   logic [15:0] ifmap_data_M2P;
   logic [15:0] fltr_data_M2P;
   logic [31:0] psum_data_M2P;
   logic [7:0]  pe_kernel_size;
   logic        PE_READY;
   logic        PE_VALID;
   logic [31:0] psum_data_P2M;

   int          errors = 0;
   int          checks = 0;
   int          peEnCount = 0;
   logic [31:0] rxQ[$];
   logic [31:0] pendQ[$];
   logic        peModel;
   logic        peValidDrv;
   logic [31:0] psumDrv;
   int          peBase;
   int          rxBase;

   multi_caster dut (
      .clk            (clk),
      .rst            (rst),
      .ID             (ID),
      .TAG            (TAG),
      .CASTER_EN      (CASTER_EN),
      .ifmap_data_B2M (ifmap_data_B2M),
      .fltr_data_B2M  (fltr_data_B2M),
      .psum_data_B2M  (psum_data_B2M),
      .kernel_size    (kernel_size),
      .flush          (flush),
      .READY          (READY),
      .VALID          (VALID),
      .psum_data_M2B  (psum_data_M2B),
      .ifmap_data_M2B (ifmap_data_M2B),
      .fltr_data_M2B  (fltr_data_M2B),
      .flush_BUSY     (flush_BUSY),
      .ovf_err        (ovf_err),
      .PE_EN          (PE_EN),
      .ifmap_data_M2P (ifmap_data_M2P),
      .fltr_data_M2P  (fltr_data_M2P),
      .psum_data_M2P  (psum_data_M2P),
      .pe_kernel_size (pe_kernel_size),
      .PE_READY       (PE_READY),
      .PE_VALID       (PE_VALID),
      .psum_data_P2M  (psum_data_P2M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitors and PE model, evaluated mid-cycle. The PE answers every issued
   // beat in order with {ifmap,fltr} ^ psum_in; a result handed over while
   // PE_READY is high is taken at the next rising edge, so it is retired here.
   always @(negedge clk) begin
      if (rst) begin
         pendQ.delete();
         PE_VALID      = 1'b0;
         psum_data_P2M = '0;
      end else begin
         if (PE_EN === 1'b1) begin
            peEnCount++;
            pendQ.push_back({ifmap_data_M2P, fltr_data_M2P} ^ psum_data_M2P);
         end
         if (VALID === 1'b1 && READY === 1'b1) rxQ.push_back(psum_data_M2B);
         if (peModel) begin
            PE_VALID      = (pendQ.size() > 0);
            psum_data_P2M = (pendQ.size() > 0) ? pendQ[0] : 32'h0;
            if (PE_VALID && PE_READY === 1'b1) void'(pendQ.pop_front());
         end else begin
            PE_VALID      = peValidDrv;
            psum_data_P2M = psumDrv;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one bus beat for one clock edge, then drop CASTER_EN.
   task automatic applyStimulus(input logic [1:0] tag, input logic [15:0] ifm,
                                input logic [15:0] flt, input logic [31:0] ps);
      CASTER_EN      = 1'b1;
      TAG            = tag;
      ifmap_data_B2M = ifm;
      fltr_data_B2M  = flt;
      psum_data_B2M  = ps;
      tick();
      CASTER_EN = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      CASTER_EN = 1'b0; TAG = '0; flush = 1'b0; READY = 1'b0;
      ifmap_data_B2M = '0; fltr_data_B2M = '0; psum_data_B2M = '0;
      kernel_size = '0; peModel = 1'b0; peValidDrv = 1'b0; psumDrv = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_VALID"},    VALID, 0);
      checkOutput({tag, "_PE_EN"},    PE_EN, 0);
      checkOutput({tag, "_BUSY"},     flush_BUSY, 0);
      checkOutput({tag, "_ovf"},      ovf_err, 0);
      checkOutput({tag, "_psumM2B"},  psum_data_M2B, 0);
      checkOutput({tag, "_ifmapM2B"}, ifmap_data_M2B, 0);
      checkOutput({tag, "_fltrM2B"},  fltr_data_M2B, 0);
      checkOutput({tag, "_ifmapM2P"}, ifmap_data_M2P, 0);
      checkOutput({tag, "_psumM2P"},  psum_data_M2P, 0);
      checkOutput({tag, "_kernel"},   pe_kernel_size, 0);
      checkOutput({tag, "_PE_READY"}, PE_READY, 0);
   endtask

   function automatic logic [31:0] rxAt(input int idx);
      if (idx < rxQ.size()) return rxQ[idx];
      return 'x;
   endfunction

   function automatic logic [31:0] expRes(input logic [15:0] ifm, input logic [15:0] flt,
                                          input logic [31:0] ps);
      return {ifm, flt} ^ ps;
   endfunction

   initial begin
      ID = 2'd2;
      rst = 1'b1;
      CASTER_EN = 1'b0; TAG = '0; flush = 1'b0; READY = 1'b0;
      ifmap_data_B2M = '0; fltr_data_B2M = '0; psum_data_B2M = '0;
      kernel_size = '0; peModel = 1'b0; peValidDrv = 1'b0; psumDrv = '0;
      tick();
      tick();
      $display("[TB] reset state");
      checkAllZero("rst0");
      rst = 1'b0;
      kernel_size = 8'd3;
      tick();
      checkOutput("kernel_idle_load", pe_kernel_size, 8'd3);
      checkOutput("pe_ready_idle", PE_READY, 1);

      // Test 1: matching beat issued once, non-matching beat ignored.
      $display("[TB] test 1: tag match and issue latency");
      peModel = 1'b1;
      READY = 1'b1;
      peBase = peEnCount;
      rxBase = rxQ.size();
      applyStimulus(2'd2, 16'h0011, 16'h0022, 32'h0);
      checkOutput("t1_no_issue_same_cycle", PE_EN, 0);
      applyStimulus(2'd1, 16'h0033, 16'h0044, 32'h0);
      checkOutput("t1_pe_en", PE_EN, 1);
      checkOutput("t1_ifmap_M2P", ifmap_data_M2P, 16'h0011);
      checkOutput("t1_fltr_M2P", fltr_data_M2P, 16'h0022);
      checkOutput("t1_ifmap_M2B", ifmap_data_M2B, 16'h0011);
      tick();
      checkOutput("t1_pe_en_one_cycle", PE_EN, 0);
      checkOutput("t1_fltr_M2B_hold", fltr_data_M2B, 16'h0022);
      repeat (6) tick();
      checkOutput("t1_pe_en_count", peEnCount - peBase, 1);
      checkOutput("t1_rx_count", rxQ.size() - rxBase, 1);
      checkOutput("t1_rx_data", rxAt(rxBase), 32'h0011_0022);
      checkOutput("t1_ifmap_M2B_hold", ifmap_data_M2B, 16'h0011);

      // Test 2: bus back-pressure limits issue to the result buffer depth.
      $display("[TB] test 2: result back-pressure");
      doReset();
      peValidDrv = 1'b1;
      psumDrv = 32'h0000_1234;
      peBase = peEnCount;
      rxBase = rxQ.size();
      for (int i = 0; i < 6; i++) applyStimulus(2'd2, 16'h0100 + 16'(i), 16'h0200, 32'h0);
      repeat (10) tick();
      checkOutput("t2_stalled_issue_count", peEnCount - peBase, 4);
      checkOutput("t2_valid", VALID, 1);
      checkOutput("t2_head", psum_data_M2B, 32'h0000_1234);
      checkOutput("t2_pe_ready_full", PE_READY, 0);
      checkOutput("t2_no_return_yet", rxQ.size() - rxBase, 0);
      READY = 1'b1;
      repeat (15) tick();
      checkOutput("t2_total_issue", peEnCount - peBase, 6);
      checkOutput("t2_rx_count", rxQ.size() - rxBase, 6);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_rx%0d", i), rxAt(rxBase + i), 32'h0000_1234);
      checkOutput("t2_valid_drained", VALID, 0);

      // Test 3: operand overflow with a stalled PE.
      $display("[TB] test 3: operand overflow");
      doReset();
      READY = 1'b1;
      peBase = peEnCount;
      rxBase = rxQ.size();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(2'd2, 16'h0300 + 16'(i), 16'h0400 + 16'(i), 32'hA000_0000 | 32'(i));
         if (i == 7) checkOutput("t3_ovf_before_drop", ovf_err, 0);
      end
      checkOutput("t3_ovf_set", ovf_err, 1);
      peModel = 1'b1;
      repeat (30) tick();
      checkOutput("t3_ovf_sticky", ovf_err, 1);
      checkOutput("t3_issue_count", peEnCount - peBase, 8);
      checkOutput("t3_rx_count", rxQ.size() - rxBase, 8);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("t3_rx%0d", i), rxAt(rxBase + i),
                     expRes(16'h0300 + 16'(i), 16'h0400 + 16'(i), 32'hA000_0000 | 32'(i)));

      // Test 4: flush drains buffered work and rejects the concurrent beat.
      $display("[TB] test 4: flush");
      doReset();
      kernel_size = 8'd5;
      peBase = peEnCount;
      rxBase = rxQ.size();
      for (int i = 0; i < 3; i++) applyStimulus(2'd2, 16'h0700 + 16'(i), 16'h0800 + 16'(i), 32'(i));
      kernel_size = 8'd9;
      tick();
      tick();
      checkOutput("t4_kernel_held_busy", pe_kernel_size, 8'd5);
      flush = 1'b1;
      applyStimulus(2'd2, 16'h0444, 16'h0555, 32'h0);
      flush = 1'b0;
      checkOutput("t4_busy_set", flush_BUSY, 1);
      checkOutput("t4_no_ovf", ovf_err, 0);
      peModel = 1'b1;
      repeat (6) tick();
      checkOutput("t4_busy_results_pending", flush_BUSY, 1);
      checkOutput("t4_valid_pending", VALID, 1);
      READY = 1'b1;
      tick();
      checkOutput("t4_busy_pop1", flush_BUSY, 1);
      tick();
      tick();
      checkOutput("t4_busy_pop3", flush_BUSY, 1);
      checkOutput("t4_valid_empty", VALID, 0);
      tick();
      checkOutput("t4_busy_clear", flush_BUSY, 0);
      checkOutput("t4_issue_count", peEnCount - peBase, 3);
      checkOutput("t4_rx_count", rxQ.size() - rxBase, 3);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("t4_rx%0d", i), rxAt(rxBase + i),
                     expRes(16'h0700 + 16'(i), 16'h0800 + 16'(i), 32'(i)));

      // Test 5: streaming with issue, capture and return every cycle.
      $display("[TB] test 5: streaming");
      doReset();
      peModel = 1'b1;
      READY = 1'b1;
      peBase = peEnCount;
      rxBase = rxQ.size();
      for (int i = 0; i < 14; i++) begin
         applyStimulus(2'd2, 16'h0500 + 16'(i), 16'h0600 + 16'(i), 32'(i) << 8);
         if (i >= 3 && i <= 12) begin
            checkOutput($sformatf("t5_pe_en_c%0d", i), PE_EN, 1);
            checkOutput($sformatf("t5_valid_c%0d", i), VALID, 1);
         end
      end
      repeat (6) tick();
      checkOutput("t5_rx_count", rxQ.size() - rxBase, 14);
      for (int i = 0; i < 14; i++)
         checkOutput($sformatf("t5_rx%0d", i), rxAt(rxBase + i),
                     expRes(16'h0500 + 16'(i), 16'h0600 + 16'(i), 32'(i) << 8));

      // Test 6: asynchronous reset while flushing with results buffered.
      $display("[TB] test 6: reset during flush");
      doReset();
      applyStimulus(2'd2, 16'h0901, 16'h0A01, 32'h1);
      applyStimulus(2'd2, 16'h0902, 16'h0A02, 32'h2);
      repeat (3) tick();
      peModel = 1'b1;
      repeat (4) tick();
      flush = 1'b1;
      tick();
      tick();
      checkOutput("t6_busy_before_rst", flush_BUSY, 1);
      checkOutput("t6_valid_before_rst", VALID, 1);
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("t6_async");
      flush = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      checkOutput("t6_state_run", flush_BUSY, 0);
      checkOutput("t6_valid_after", VALID, 0);
      checkOutput("t6_pe_en_after", PE_EN, 0);
      checkOutput("t6_pe_ready_after", PE_READY, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
